conv2_calc_5ks: RTL and testbench

Compute stage directly downstream of the conv2 5x5 window buffer. Each cycle it takes one 25-pixel window, 75 weights (3 kernels × 25) and 3 biases, and computes three output-channel results. Each result is multiply-accumulate plus bias, then ReLU, right shift and saturation. Fully pipelined: one window per cycle, fixed latency, plus a per-frame output counter that pulses at frame end.

---
 rtl/conv2_calc_5ks.sv | 217 +++++++++++++++++++++
 tb/tb_conv2_calc_5ks.sv | 272 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/conv2_calc_5ks.sv
// ---------------------------------------------------------------------------
// conv2_calc_5ks
//
// Compute stage that follows the conv2 5x5 window buffer. Every cycle it
// accepts one 25-pixel window together with 3 kernels of 25 signed 4-bit
// weights and 3 signed 8-bit biases. It produces three output-channel
// results: multiply-accumulate plus bias, then ReLU, an arithmetic right
// shift and saturation to the unsigned pixel range.
//
// The pipeline is fully streaming, with one window per cycle and a fixed
// latency of 4 cycles. There is no stall or back-pressure. A frame counter
// pulses frame_done together with the last output of each frame.
//
// Ports
//   clk        : clock
//   rst        : synchronous, active-high reset
//   valid_in   : window / weights / biases valid this cycle
//   in_window  : pixel i (i = row*5+col, row 0 oldest) at [i*DATA_BIT +: DATA_BIT]
//   in_weight  : weight for channel k, position i at [(k*25+i)*4 +: 4], signed
//   in_bias    : bias for channel k at [k*8 +: 8], signed
//   out_ch0..2 : unsigned channel results, meaningful when valid_out = 1
//   valid_out  : results valid
//   frame_done : one-cycle pulse with the last valid output of a frame
// ---------------------------------------------------------------------------
module conv2_calc_5ks #(
    parameter int WIDTH     = 12,
    parameter int HEIGHT    = 12,
    parameter int DATA_BIT  = 12,
    parameter int OUT_SHIFT = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     valid_in,
    input  logic [25*DATA_BIT-1:0]   in_window,
    input  logic [299:0]             in_weight,
    input  logic [23:0]              in_bias,
    output logic [DATA_BIT-1:0]      out_ch0,
    output logic [DATA_BIT-1:0]      out_ch1,
    output logic [DATA_BIT-1:0]      out_ch2,
    output logic                     valid_out,
    output logic                     frame_done
);

    // A (DATA_BIT+1)-bit non-negative pixel times a 4-bit signed weight
    // fits in DATA_BIT+5 bits. 25 products plus an 8-bit bias fit
    // comfortably in DATA_BIT+10 bits, so the sums never overflow.
    localparam int PROD_W  = DATA_BIT + 5;
    localparam int ACC_W   = DATA_BIT + 10;
    localparam int FRAME_N = (WIDTH - 4) * (HEIGHT - 4);
    localparam int CNT_W   = (FRAME_N > 1) ? $clog2(FRAME_N) : 1;

    localparam logic signed [ACC_W-1:0] OUT_MAX = ACC_W'((1 << DATA_BIT) - 1);
    localparam logic [CNT_W-1:0]        CNT_LAST = CNT_W'(FRAME_N - 1);

    // Pixel is zero-extended to signed, weight sign-extended, then multiplied.
    function automatic logic signed [PROD_W-1:0] mul_px(
        input logic [DATA_BIT-1:0] px,
        input logic [3:0]          w
    );
        logic signed [DATA_BIT:0]  px_s;
        logic signed [3:0]         w_s;
        logic signed [PROD_W-1:0]  a;
        logic signed [PROD_W-1:0]  b;
        px_s = {1'b0, px};
        w_s  = w;
        a    = PROD_W'(px_s);
        b    = PROD_W'(w_s);
        mul_px = a * b;
    endfunction

    // ReLU, then arithmetic shift, then clamp to the unsigned pixel range.
    function automatic logic [DATA_BIT-1:0] relu_shift_sat(
        input logic signed [ACC_W-1:0] v
    );
        logic signed [ACC_W-1:0] s;
        s = v >>> OUT_SHIFT;
        if (v[ACC_W-1]) begin
            relu_shift_sat = '0;
        end else if (s > OUT_MAX) begin
            relu_shift_sat = '1;
        end else begin
            relu_shift_sat = s[DATA_BIT-1:0];
        end
    endfunction

    logic signed [PROD_W-1:0] prod_p1 [3][25];
    logic signed [7:0]        bias_p1 [3];
    logic                     vld_p1;

    logic signed [ACC_W-1:0]  row_sum [3][5];
    logic signed [ACC_W-1:0]  row_p2  [3][5];
    logic signed [7:0]        bias_p2 [3];
    logic                     vld_p2;

    logic signed [ACC_W-1:0]  chan_sum [3];
    logic signed [ACC_W-1:0]  sum_p3   [3];
    logic                     vld_p3;

    logic [DATA_BIT-1:0]      out_p4 [3];
    logic                     vld_p4;
    logic                     done_p4;
    logic [CNT_W-1:0]         cnt_p4;

    // ---- Stage 1: sample inputs, register all 75 products ----------------
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int k = 0; k < 3; k++) begin
                for (int i = 0; i < 25; i++) begin
                    prod_p1[k][i] <= '0;
                end
                bias_p1[k] <= '0;
            end
            vld_p1 <= 1'b0;
        end else begin
            for (int k = 0; k < 3; k++) begin
                for (int i = 0; i < 25; i++) begin
                    prod_p1[k][i] <= mul_px(in_window[i*DATA_BIT +: DATA_BIT],
                                            in_weight[(k*25+i)*4 +: 4]);
                end
                bias_p1[k] <= in_bias[k*8 +: 8];
            end
            vld_p1 <= valid_in;
        end
    end

    // ---- Stage 2: 15 row sums (5 products each) ---------------------------
    always_comb begin
        for (int k = 0; k < 3; k++) begin
            for (int r = 0; r < 5; r++) begin
                row_sum[k][r] = '0;
                for (int c = 0; c < 5; c++) begin
                    row_sum[k][r] = row_sum[k][r] + ACC_W'(prod_p1[k][r*5+c]);
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int k = 0; k < 3; k++) begin
                for (int r = 0; r < 5; r++) begin
                    row_p2[k][r] <= '0;
                end
                bias_p2[k] <= '0;
            end
            vld_p2 <= 1'b0;
        end else begin
            for (int k = 0; k < 3; k++) begin
                for (int r = 0; r < 5; r++) begin
                    row_p2[k][r] <= row_sum[k][r];
                end
                bias_p2[k] <= bias_p1[k];
            end
            vld_p2 <= vld_p1;
        end
    end

    // ---- Stage 3: channel sum plus bias ------------------------------------
    always_comb begin
        for (int k = 0; k < 3; k++) begin
            chan_sum[k] = ACC_W'(bias_p2[k]);
            for (int r = 0; r < 5; r++) begin
                chan_sum[k] = chan_sum[k] + row_p2[k][r];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int k = 0; k < 3; k++) begin
                sum_p3[k] <= '0;
            end
            vld_p3 <= 1'b0;
        end else begin
            for (int k = 0; k < 3; k++) begin
                sum_p3[k] <= chan_sum[k];
            end
            vld_p3 <= vld_p2;
        end
    end

    // ---- Stage 4: ReLU / shift / saturate, frame counter -------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int k = 0; k < 3; k++) begin
                out_p4[k] <= '0;
            end
            vld_p4  <= 1'b0;
            done_p4 <= 1'b0;
            cnt_p4  <= '0;
        end else begin
            for (int k = 0; k < 3; k++) begin
                out_p4[k] <= relu_shift_sat(sum_p3[k]);
            end
            vld_p4  <= vld_p3;
            done_p4 <= 1'b0;
            if (vld_p3) begin
                // The counter holds the number of outputs already emitted
                // in this frame, so the output leaving now is the last one
                // when the counter sits at N-1.
                if (cnt_p4 == CNT_LAST) begin
                    cnt_p4  <= '0;
                    done_p4 <= 1'b1;
                end else begin
                    cnt_p4 <= cnt_p4 + CNT_W'(1);
                end
            end
        end
    end

    assign out_ch0    = out_p4[0];
    assign out_ch1    = out_p4[1];
    assign out_ch2    = out_p4[2];
    assign valid_out  = vld_p4;
    assign frame_done = done_p4;

endmodule

// File: tb/tb_conv2_calc_5ks.sv
// ---------------------------------------------------------------------------
// tb_conv2_calc_5ks
//
// Two instances of conv2_calc_5ks share one stimulus stream: one with
// OUT_SHIFT=0 and one with OUT_SHIFT=4. The driver pushes each accepted
// window's expected results into one queue per instance. Independent
// monitors pop and compare whenever an instance raises valid_out.
// ---------------------------------------------------------------------------
module tb_conv2_calc_5ks;

    localparam int DB      = 12;
    localparam int FRAME_N = 64;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              valid_in = 1'b0;
    logic [25*DB-1:0]  in_window = '0;
    logic [299:0]      in_weight = '0;
    logic [23:0]       in_bias = '0;

    logic [DB-1:0] a_ch0, a_ch1, a_ch2, b_ch0, b_ch1, b_ch2;
    logic          a_vo, a_fd, b_vo, b_fd;

    conv2_calc_5ks #(.WIDTH(12), .HEIGHT(12), .DATA_BIT(DB), .OUT_SHIFT(0)) dut_s0 (
        .clk(clk), .rst(rst), .valid_in(valid_in), .in_window(in_window),
        .in_weight(in_weight), .in_bias(in_bias), .out_ch0(a_ch0), .out_ch1(a_ch1),
        .out_ch2(a_ch2), .valid_out(a_vo), .frame_done(a_fd));

    conv2_calc_5ks #(.WIDTH(12), .HEIGHT(12), .DATA_BIT(DB), .OUT_SHIFT(4)) dut_s4 (
        .clk(clk), .rst(rst), .valid_in(valid_in), .in_window(in_window),
        .in_weight(in_weight), .in_bias(in_bias), .out_ch0(b_ch0), .out_ch1(b_ch1),
        .out_ch2(b_ch2), .valid_out(b_vo), .frame_done(b_fd));

    always #5 clk = ~clk;

    typedef struct {
        int c0;
        int c1;
        int c2;
        bit fd;
        int issue;
    } exp_t;

    exp_t q0[$];
    exp_t q4[$];

    int total = 0;
    int bad   = 0;
    int cycle = 0;
    int mcount = 0;

    int pix [25];
    int wt  [3][25];
    int bs  [3];

    always @(posedge clk) cycle <= cycle + 1;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d want %0d (cycle %0d)", nm, act, exp, cycle);
        end
    endtask

    // Reference: plain integer convolution, ReLU, shift, clamp.
    function automatic int ref_ch(input int k, input int sh);
        int acc;
        acc = bs[k];
        for (int i = 0; i < 25; i++) acc += pix[i] * wt[k][i];
        if (acc < 0) acc = 0;
        acc = acc >>> sh;
        if (acc > 4095) acc = 4095;
        return acc;
    endfunction

    task automatic pack();
        for (int i = 0; i < 25; i++) in_window[i*DB +: DB] = DB'(pix[i]);
        for (int k = 0; k < 3; k++) begin
            for (int i = 0; i < 25; i++) in_weight[(k*25+i)*4 +: 4] = 4'(wt[k][i]);
            in_bias[k*8 +: 8] = 8'(bs[k]);
        end
    endtask

    task automatic set_uniform(input int p, input int w0, input int w1, input int w2,
                               input int b0, input int b1, input int b2);
        for (int i = 0; i < 25; i++) begin
            pix[i] = p; wt[0][i] = w0; wt[1][i] = w1; wt[2][i] = w2;
        end
        bs[0] = b0; bs[1] = b1; bs[2] = b2;
    endtask

    task automatic set_random();
        for (int i = 0; i < 25; i++) begin
            pix[i] = int'($urandom_range(0, 4095));
            for (int k = 0; k < 3; k++) wt[k][i] = int'($urandom_range(0, 15)) - 8;
        end
        for (int k = 0; k < 3; k++) bs[k] = int'($urandom_range(0, 255)) - 128;
    endtask

    // One clock cycle of stimulus; an accepted window is scored at its edge.
    task automatic issue(input bit v);
        exp_t e;
        pack();
        valid_in = v;
        @(posedge clk);
        if (v && !rst) begin
            mcount++;
            e.fd = (mcount == FRAME_N);
            if (e.fd) mcount = 0;
            e.issue = cycle;
            e.c0 = ref_ch(0, 0); e.c1 = ref_ch(1, 0); e.c2 = ref_ch(2, 0);
            q0.push_back(e);
            e.c0 = ref_ch(0, 4); e.c1 = ref_ch(1, 4); e.c2 = ref_ch(2, 4);
            q4.push_back(e);
        end
        #1;
        valid_in = 1'b0;
    endtask

    // Reset with valid_in held high, which must be ignored; anything in flight is dropped.
    task automatic do_reset(input int n);
        set_random();
        pack();
        rst = 1'b1;
        valid_in = 1'b1;
        repeat (n) begin
            @(posedge clk);
            q0.delete();
            q4.delete();
            mcount = 0;
        end
        #1;
        rst = 1'b0;
        valid_in = 1'b0;
    endtask

    task automatic check_zero(input string tag);
        chk({tag, " vo_s0"}, 32'(a_vo), 0);
        chk({tag, " fd_s0"}, 32'(a_fd), 0);
        chk({tag, " ch0_s0"}, 32'(a_ch0), 0);
        chk({tag, " ch1_s0"}, 32'(a_ch1), 0);
        chk({tag, " ch2_s0"}, 32'(a_ch2), 0);
        chk({tag, " vo_s4"}, 32'(b_vo), 0);
        chk({tag, " ch0_s4"}, 32'(b_ch0), 0);
    endtask

    task automatic drain();
        for (int n = 0; n < 20 && (q0.size() != 0 || q4.size() != 0); n++) @(posedge clk);
        #1;
        chk("drain_q_s0", 32'(q0.size()), 0);
        chk("drain_q_s4", 32'(q4.size()), 0);
    endtask

    task automatic mon(input int d, input logic vo, input logic fd,
                       input logic [DB-1:0] c0, input logic [DB-1:0] c1, input logic [DB-1:0] c2);
        exp_t e;
        string s;
        s = (d == 0) ? "s0" : "s4";
        if (vo) begin
            if ((d == 0 && q0.size() == 0) || (d == 4 && q4.size() == 0)) begin
                chk({"unexpected_valid_", s}, 32'(vo), 0);
            end else begin
                if (d == 0) e = q0.pop_front();
                else        e = q4.pop_front();
                chk({"latency_", s}, 32'(cycle - e.issue), 4);
                chk({"ch0_", s}, 32'(c0), 32'(e.c0));
                chk({"ch1_", s}, 32'(c1), 32'(e.c1));
                chk({"ch2_", s}, 32'(c2), 32'(e.c2));
                chk({"frame_done_", s}, 32'(fd), 32'(e.fd));
            end
        end else begin
            chk({"fd_without_valid_", s}, 32'(fd), 0);
            if (d == 0 && q0.size() != 0 && cycle - q0[0].issue > 4) begin
                e = q0.pop_front();
                chk("missing_valid_s0", 32'(vo), 1);
            end
            if (d == 4 && q4.size() != 0 && cycle - q4[0].issue > 4) begin
                e = q4.pop_front();
                chk("missing_valid_s4", 32'(vo), 1);
            end
        end
    endtask

    always @(negedge clk) begin
        mon(0, a_vo, a_fd, a_ch0, a_ch1, a_ch2);
        mon(4, b_vo, b_fd, b_ch0, b_ch1, b_ch2);
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout want completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        do_reset(3);
        check_zero("reset");
        repeat (2) issue(1'b0);

        // Unit sum: 25 in every channel before shifting.
        set_uniform(1, 1, 1, 1, 0, 0, 0);
        issue(1'b1);
        repeat (6) issue(1'b0);

        // Signed weights and ReLU: -245 -> 0, 490, -128 -> 0.
        set_uniform(10, -1, 2, 0, 5, -10, -128);
        issue(1'b1);
        repeat (6) issue(1'b0);

        // Saturation at full scale, then an exact shift case.
        set_uniform(4095, 7, 7, 7, 127, 127, 127);
        issue(1'b1);
        set_uniform(16, 1, 1, 1, 0, 0, 0);
        issue(1'b1);
        repeat (6) issue(1'b0);

        // Throughput with a gap: 1,1,0,1.
        set_random(); issue(1'b1);
        set_random(); issue(1'b1);
        set_random(); issue(1'b0);
        set_random(); issue(1'b1);
        repeat (6) issue(1'b0);
        drain();

        // Two full frames from a clean count, random gaps and windows.
        do_reset(1);
        check_zero("reset2");
        for (int n = 0; n < 2 * FRAME_N; ) begin
            bit v;
            set_random();
            v = ($urandom_range(0, 2) != 0);
            issue(v);
            if (v) n++;
        end
        repeat (6) issue(1'b0);
        drain();

        // Partial frame, then reset with three windows in flight.
        for (int n = 0; n < 10; n++) begin
            set_random();
            issue(1'b1);
        end
        repeat (6) issue(1'b0);
        for (int n = 0; n < 3; n++) begin
            set_random();
            issue(1'b1);
        end
        do_reset(1);
        check_zero("midreset");
        repeat (3) begin
            issue(1'b0);
            chk("post_reset_quiet_s0", 32'(a_vo), 0);
            chk("post_reset_quiet_s4", 32'(b_vo), 0);
        end

        // A fresh frame must end exactly on its 64th output.
        for (int n = 0; n < FRAME_N + 5; ) begin
            bit v;
            set_random();
            v = ($urandom_range(0, 3) != 0);
            issue(v);
            if (v) n++;
        end
        repeat (6) issue(1'b0);
        drain();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
